// File: rtl/gcd_pkg.sv
// gcd_pkg: shared FSM state encoding and default operand width for the GCD block.
package gcd_pkg;
    localparam int GCD_W = 8;
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/gcd_if.sv
// gcd_if: operand/result handshake bundle.
//   in_valid/in_ready/a/b       : operand pair from producer
//   out_valid/out_ready/result/iters : result to consumer
//   busy                        : high while the block is iterating
interface gcd_if import gcd_pkg::*; #(parameter int W = GCD_W);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [W-1:0] iters;
    logic         busy;
    modport master (output in_valid, a, b, out_ready, input in_ready, out_valid, result, iters, busy);
    modport slave  (input in_valid, a, b, out_ready, output in_ready, out_valid, result, iters, busy);
endinterface

// File: rtl/gcd_datapath.sv
// gcd_datapath: x/y operand registers, MSB-first 2-bit-slice comparator and one shared subtractor.
//   load_i : capture a_i/b_i into x/y      step_i : replace the larger of x/y by |x-y|
//   x_gt_y_o/x_lt_y_o/x_eq_y_o/x_zero_o/y_zero_o : compare flags   x_o/y_o : register values
module gcd_datapath import gcd_pkg::*; #(parameter int W = GCD_W) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         step_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         x_gt_y_o,
    output logic         x_lt_y_o,
    output logic         x_eq_y_o,
    output logic         x_zero_o,
    output logic         y_zero_o,
    output logic [W-1:0] x_o,
    output logic [W-1:0] y_o
);
    logic [W-1:0] x_q, x_d, y_q, y_d, diff;
    logic         gt, eq;
    // The first differing slice from the top decides the ordering.
    always_comb begin
        gt = 1'b0;
        eq = 1'b1;
        for (int i = W/2-1; i >= 0; i--) begin
            gt = gt | (eq & (x_q[2*i +: 2] > y_q[2*i +: 2]));
            eq = eq & (x_q[2*i +: 2] == y_q[2*i +: 2]);
        end
    end
    // Larger value is always the minuend, so the difference never wraps.
    assign diff = gt ? x_q - y_q : y_q - x_q;
    always_comb begin
        x_d = load_i ? a_i : (step_i && gt) ? diff : x_q;
        y_d = load_i ? b_i : (step_i && !gt) ? diff : y_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end
    assign x_gt_y_o = gt;
    assign x_lt_y_o = !gt && !eq;
    assign x_eq_y_o = eq;
    assign x_zero_o = x_q == '0;
    assign y_zero_o = y_q == '0;
    assign x_o      = x_q;
    assign y_o      = y_q;
endmodule

// File: rtl/gcd_controller.sv
// gcd_controller: subtractive Euclid GCD sequencer with valid/ready operand and result handshakes.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : gcd_if slave (operands in, result/iters out, busy)
module gcd_controller import gcd_pkg::*; #(parameter int W = GCD_W) (
    input logic clk,
    input logic rst_n,
    gcd_if.slave bus
);
    logic [1:0]   state_q, state_d;
    logic [W-1:0] iters_q, iters_d, result_q, result_d, x, y;
    logic         in_ready_q, load, step, fin, x_gt_y, x_lt_y, x_eq_y, x_zero, y_zero;
    gcd_datapath #(.W(W)) u_dp (
        .clk(clk), .rst_n(rst_n), .load_i(load), .step_i(step), .a_i(bus.a), .b_i(bus.b),
        .x_gt_y_o(x_gt_y), .x_lt_y_o(x_lt_y), .x_eq_y_o(x_eq_y), .x_zero_o(x_zero), .y_zero_o(y_zero),
        .x_o(x), .y_o(y)
    );
    // in_ready_q is only ever set while heading into IDLE, so it alone qualifies acceptance.
    assign load = in_ready_q && bus.in_valid;
    assign fin  = state_q == CALC && (x_zero || y_zero || x_eq_y);
    assign step = state_q == CALC && !x_zero && !y_zero && (x_gt_y || x_lt_y);
    always_comb begin
        state_d  = load ? CALC : fin ? DONE :
                   ((state_q == DONE && bus.out_ready) || state_q == 2'd3) ? IDLE : state_q;
        iters_d  = load ? '0 : step ? iters_q + 1'b1 : iters_q;
        result_d = fin ? ((x_zero || y_zero) ? (x | y) : x) : result_q;
    end
    // in_ready is registered so it stays low through reset and rises one edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            iters_q    <= '0;
            result_q   <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            iters_q    <= iters_d;
            result_q   <= result_d;
            in_ready_q <= state_d == IDLE;
        end
    end
    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = state_q == DONE;
    assign bus.busy      = state_q == CALC;
    assign bus.result    = result_q;
    assign bus.iters     = iters_q;
endmodule

// File: tb/tb_gcd_controller.sv
// tb_gcd_controller: directed vectors with a scoreboard queue checked by an output monitor.
module tb_gcd_controller;
    import gcd_pkg::*;
    localparam int W = GCD_W;
    typedef struct {logic [W-1:0] r; logic [W-1:0] it; int cyc;} exp_t;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;
    gcd_if #(.W(W)) bus();
    gcd_controller #(.W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    int   bcnt  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: counts busy cycles and checks each result as it is handed off.
    always @(negedge clk) begin
        if (!rst_n) bcnt = 0;
        else begin
            if (bus.busy) bcnt++;
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got result %0d with nothing expected", bus.result);
                end else begin
                    mon_e = sb.pop_front();
                    chk("result", 32'(bus.result), 32'(mon_e.r));
                    chk("iters", 32'(bus.iters), 32'(mon_e.it));
                    chk("busy_cycles", bcnt, mon_e.cyc);
                end
                bcnt = 0;
            end
        end
    end

    task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic [W-1:0] er, input logic [W-1:0] ei);
        int n = 0;
        bus.a = xa;
        bus.b = xb;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 600) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: in_ready still %0b after %0d cycles, expected 1", bus.in_ready, n);
        end else begin
            @(posedge clk); #1;
            sb.push_back('{er, ei, int'(ei) + 1});
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() > 0 && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d results pending, expected 0", sb.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.a = '0;
        bus.b = '0;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(bus.in_ready), 0);
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_result", 32'(bus.result), 0);
        chk("rst_iters", 32'(bus.iters), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 32'(bus.in_ready), 1);

        send(48, 18, 6, 4);
        bus.in_valid = 1'b0;
        wait_done();
        chk("ready_after_hs", 32'(bus.in_ready), 1);

        send(255, 1, 1, 254);
        bus.in_valid = 1'b0;
        wait_done();

        send(0, 7, 7, 0);
        bus.in_valid = 1'b0;
        wait_done();
        send(0, 0, 0, 0);
        bus.in_valid = 1'b0;
        wait_done();
        send(9, 9, 9, 0);
        bus.in_valid = 1'b0;
        wait_done();

        bus.out_ready = 1'b0;
        send(21, 14, 7, 2);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        bus.a = 8'd1;
        bus.b = 8'd1;
        for (int i = 0; i < 10; i++) begin
            chk("stall_out_valid", 32'(bus.out_valid), 1);
            chk("stall_result", 32'(bus.result), 7);
            chk("stall_iters", 32'(bus.iters), 2);
            chk("stall_in_ready", 32'(bus.in_ready), 0);
            bus.in_valid = ~bus.in_valid;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release_in_ready", 32'(bus.in_ready), 1);
        chk("stall_release_out_valid", 32'(bus.out_valid), 0);
        chk("stall_pending", sb.size(), 0);

        send(200, 3, 1, 68);
        bus.in_valid = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("midcalc_busy", 32'(bus.busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_busy", 32'(bus.busy), 0);
        chk("async_out_valid", 32'(bus.out_valid), 0);
        chk("async_in_ready", 32'(bus.in_ready), 0);
        chk("async_result", 32'(bus.result), 0);
        chk("async_iters", 32'(bus.iters), 0);
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("async_post_in_ready", 32'(bus.in_ready), 1);
        send(12, 8, 4, 2);
        bus.in_valid = 1'b0;
        wait_done();

        send(10, 4, 2, 3);
        send(7, 5, 1, 4);
        bus.in_valid = 1'b0;
        wait_done();
        repeat (20) @(posedge clk);
        #1;
        chk("b2b_no_extra", sb.size(), 0);
        chk("b2b_idle", 32'(bus.in_ready), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
